rv_wb_arbiter: RTL
==================

Name: rv_wb_arbiter

Overview:
- Writer-side companion to the rv_reg_file module in this codebase.
- Accepts writeback results from the ALU and the LSU through valid/ready handshakes and arbitrates them onto the single register-file write port (rd_addr/wr_en/wr_data). The write port is registered.
- Keeps a per-register pending scoreboard, which decode uses for RAW/WAW hazard stalls.

Parameters:
- XLEN, 32, data width of results and of the write port.
- NREGS, 32, number of architectural registers; address width is $clog2(NREGS) = 5.
- STARVE_LIMIT, 2, consecutive ALU losses after which the ALU wins priority.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset_n  in  1  synchronous active-low reset.
- issue_valid_i  in  1  decode issues an instruction that writes issue_rd_i.
- issue_rd_i  in  5  destination register of the issuing instruction.
- issue_ready_o  out  1  issue accepted this cycle.
- alu_valid_i / alu_rd_i[5] / alu_data_i[XLEN]  in  ALU result request.
- alu_ready_o  out  1  ALU request accepted this cycle.
- lsu_valid_i / lsu_rd_i[5] / lsu_data_i[XLEN]  in  load result request.
- lsu_ready_o  out  1  LSU request accepted this cycle.
- rs1_addr_i, rs2_addr_i  in  5  source registers probed by decode.
- rs1_busy_o, rs2_busy_o  out  1  source has an outstanding write.
- rd_addr_o  out  5  register-file write address.
- wr_en_o  out  1  register-file write enable.
- wr_data_o  out  XLEN  register-file write data.
- wb_err_o  out  1  sticky error flag.

Behaviour:
- Reset (reset_n=0 at posedge):
  - pending[31:0]=0, wr_en_o=0, rd_addr_o=0, wr_data_o=0, wb_err_o=0, starvation counter=0.
  - Applied mid-operation, reset drops any in-flight write; the next cycle has wr_en_o=0.
- Issue and scoreboard:
  - issue_ready_o = !pending[issue_rd_i] (WAW stall).
  - On issue_valid_i && issue_ready_o && issue_rd_i!=0: set pending[issue_rd_i] at the next edge.
  - Issue to x0 is always ready and never sets pending.
  - pending[0] is constant 0.
- Arbitration (combinational grant):
  - Only one valid: that source is granted.
  - Both valid: LSU wins, unless the starvation counter equals STARVE_LIMIT, in which case the ALU wins.
  - Counter increments on each ALU loss, resets to 0 on an ALU grant, and saturates at STARVE_LIMIT.
  - alu_ready_o / lsu_ready_o = grant for that source. Ready never depends on the write-port state; the write port is never back-pressured.
- Write port:
  - A request granted in cycle N drives rd_addr_o/wr_data_o with wr_en_o=1 in cycle N+1. rv_reg_file commits it at the end of cycle N+1.
  - A granted request with rd=0 is consumed but produces wr_en_o=0.
  - If no grant in N, wr_en_o=0 in N+1; rd_addr_o/wr_data_o hold their previous values.
- Scoreboard clear:
  - pending[rd_addr_o] clears at the posedge ending a cycle with wr_en_o=1.
  - Clear and set of the same register at the same edge cannot occur, because issue is blocked while pending.
  - Set and clear of different registers at the same edge both take effect.
- Busy:
  - rsX_busy_o = pending[rsX_addr_i]. It stays 1 during the wr_en_o cycle, because the register file returns the old value in that cycle.
  - Address 0 is never busy.
- Error: a granted request with rd!=0 whose pending bit is 0 sets wb_err_o=1. wb_err_o stays 1 until reset. The write still proceeds.

Optional Feature:
- Macro: RV_WB_BYPASS_EN.
- When defined:
  - Add outputs rs1_fwd_o, rs2_fwd_o (XLEN).
  - rsX_busy_o is deasserted in the wr_en_o cycle when rd_addr_o==rsX_addr_i (nonzero); rsX_fwd_o=wr_data_o in that case, else 0.
  - This saves one stall cycle on RAW hazards.
- When undefined: no fwd ports, and busy behaves as in Behaviour.

Decomposition:
- Package rv_wb_pkg holds:
  - XLEN_DEF, NREGS_DEF, REG_ADDR_W=5.
  - typedef wb_req_t {logic valid; logic [4:0] rd; logic [XLEN-1:0] data;}.
  - enum wb_src_e {WB_SRC_NONE, WB_SRC_ALU, WB_SRC_LSU}.
- One sub-module: rv_wb_scoreboard, containing the pending vector, set/clear logic and busy lookups.
- Arbiter and write-port register stay at top level.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles with both sources valid -> wr_en_o=0, all busy=0, wb_err_o=0; first write appears only after reset release.
- Single ALU path:
  - Issue rd=5; rs1_addr=5 -> rs1_busy_o=1 next cycle.
  - ALU valid rd=5 data=0xDEADBEEF -> alu_ready_o=1, next cycle wr_en_o=1 rd_addr_o=5 wr_data_o=0xDEADBEEF.
  - Following cycle rs1_busy_o=0.
- Contention:
  - Issue rd=3 and rd=4; ALU rd=3 and LSU rd=4 valid together -> LSU granted first, ALU on the next cycle.
  - With STARVE_LIMIT=2 and the LSU valid continuously, the ALU is granted on its 3rd cycle of waiting.
- Hazards:
  - Issue rd=7 twice back-to-back -> second issue_ready_o=0 until the cycle after the rd=7 write.
  - Issue rd=0 -> always ready; busy never set.
  - ALU rd=0 -> alu_ready_o=1, wr_en_o stays 0.
- Error: ALU writes rd=9 with no prior issue -> wr_en_o=1 to x9, wb_err_o=1 and held across 10 idle cycles.
- Bypass (RV_WB_BYPASS_EN defined): pending rd=12 written with 0x1234 while rs2_addr_i=12 -> in the wr_en_o cycle rs2_busy_o=0, rs2_fwd_o=0x1234.

Source files
------------

// File: rtl/rv_wb_pkg.sv
// rv_wb_pkg: shared widths, writeback request type and source encoding for rv_wb_arbiter.
package rv_wb_pkg;
  localparam int XLEN_DEF = 32;
  localparam int NREGS_DEF = 32;
  localparam int REG_ADDR_W = 5;
  typedef struct packed {
    logic valid;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN_DEF-1:0] data;
  } wb_req_t;
  typedef enum logic [1:0] {WB_SRC_NONE, WB_SRC_ALU, WB_SRC_LSU} wb_src_e;
endpackage

// File: rtl/rv_wb_scoreboard.sv
// rv_wb_scoreboard: per-register pending bits with set/clear and source busy lookups.
// RV_WB_BYPASS_EN hides busy for a source being written this cycle.
module rv_wb_scoreboard
  import rv_wb_pkg::*;
#(
  parameter int NREGS = NREGS_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  set_en,
  input  logic [REG_ADDR_W-1:0] set_addr,
  input  logic                  clr_en,
  input  logic [REG_ADDR_W-1:0] clr_addr,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic [NREGS-1:0]      pending,
  output logic                  rs1_busy,
  output logic                  rs2_busy
);
  logic [NREGS-1:0] set_mask, clr_mask;
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    set_mask[set_addr] = set_en && set_addr != '0;
    clr_mask[clr_addr] = clr_en;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) pending <= '0;
    else pending <= (pending | set_mask) & ~clr_mask;
  end
`ifdef RV_WB_BYPASS_EN
  assign rs1_busy = pending[rs1_addr] && !(clr_en && clr_addr == rs1_addr);
  assign rs2_busy = pending[rs2_addr] && !(clr_en && clr_addr == rs2_addr);
`else
  assign rs1_busy = pending[rs1_addr];
  assign rs2_busy = pending[rs2_addr];
`endif
endmodule

// File: rtl/rv_wb_arbiter.sv
// rv_wb_arbiter: arbitrates ALU/LSU writebacks onto a registered register-file write port.
// RV_WB_BYPASS_EN adds rs1_fwd_o/rs2_fwd_o forwarding from the write port.
module rv_wb_arbiter
  import rv_wb_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int STARVE_LIMIT = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  issue_valid_i,
  input  logic [REG_ADDR_W-1:0] issue_rd_i,
  output logic                  issue_ready_o,
  input  logic                  alu_valid_i,
  input  logic [REG_ADDR_W-1:0] alu_rd_i,
  input  logic [XLEN-1:0]       alu_data_i,
  output logic                  alu_ready_o,
  input  logic                  lsu_valid_i,
  input  logic [REG_ADDR_W-1:0] lsu_rd_i,
  input  logic [XLEN-1:0]       lsu_data_i,
  output logic                  lsu_ready_o,
  input  logic [REG_ADDR_W-1:0] rs1_addr_i,
  input  logic [REG_ADDR_W-1:0] rs2_addr_i,
  output logic                  rs1_busy_o,
  output logic                  rs2_busy_o,
`ifdef RV_WB_BYPASS_EN
  output logic [XLEN-1:0]       rs1_fwd_o,
  output logic [XLEN-1:0]       rs2_fwd_o,
`endif
  output logic [REG_ADDR_W-1:0] rd_addr_o,
  output logic                  wr_en_o,
  output logic [XLEN-1:0]       wr_data_o,
  output logic                  wb_err_o
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);
  logic [CW-1:0] starve;
  logic [NREGS-1:0] pending;
  wb_req_t alu_req, lsu_req, gnt_req;
  wb_src_e src;
  assign alu_req = {alu_valid_i, alu_rd_i, alu_data_i};
  assign lsu_req = {lsu_valid_i, lsu_rd_i, lsu_data_i};
  // LSU has priority; a starved ALU overrides it once
  always_comb begin
    src = (alu_valid_i && (!lsu_valid_i || starve == LIM)) ? WB_SRC_ALU :
          lsu_valid_i ? WB_SRC_LSU : WB_SRC_NONE;
    gnt_req = src == WB_SRC_ALU ? alu_req : src == WB_SRC_LSU ? lsu_req : '0;
  end
  assign alu_ready_o = src == WB_SRC_ALU;
  assign lsu_ready_o = src == WB_SRC_LSU;
  assign issue_ready_o = !pending[issue_rd_i];
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_en_o <= 1'b0;
      rd_addr_o <= '0;
      wr_data_o <= '0;
      wb_err_o <= 1'b0;
      starve <= '0;
    end else begin
      wr_en_o <= gnt_req.valid && gnt_req.rd != '0;
      if (gnt_req.valid) begin
        rd_addr_o <= gnt_req.rd;
        wr_data_o <= gnt_req.data;
      end
      if (gnt_req.valid && gnt_req.rd != '0 && !pending[gnt_req.rd]) wb_err_o <= 1'b1;
      starve <= src == WB_SRC_ALU ? '0 :
                (src == WB_SRC_LSU && alu_valid_i && starve != LIM) ? starve + 1'b1 : starve;
    end
  end
  rv_wb_scoreboard #(.NREGS(NREGS)) u_sb (
    .clk      (clk),
    .reset_n  (reset_n),
    .set_en   (issue_valid_i && issue_ready_o),
    .set_addr (issue_rd_i),
    .clr_en   (wr_en_o),
    .clr_addr (rd_addr_o),
    .rs1_addr (rs1_addr_i),
    .rs2_addr (rs2_addr_i),
    .pending  (pending),
    .rs1_busy (rs1_busy_o),
    .rs2_busy (rs2_busy_o)
  );
`ifdef RV_WB_BYPASS_EN
  assign rs1_fwd_o = (wr_en_o && rd_addr_o == rs1_addr_i) ? wr_data_o : '0;
  assign rs2_fwd_o = (wr_en_o && rd_addr_o == rs2_addr_i) ? wr_data_o : '0;
`endif
endmodule
